// File: rtl/log_ctrl.sv
// Capture-and-readout controller for the interface event log RAM.
// Records condensed samples around a trigger, then streams the log oldest entry first.
module log_ctrl #(
    parameter  int DATA_SIZE  = 32,
    parameter  int TAG_SIZE   = 8,
    parameter  int ADDR_WIDTH = 8,
    localparam int LOG_WIDTH  = 4 + 2*DATA_SIZE + TAG_SIZE,
    localparam int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          arm_in,
    input  logic                          stop_in,
    input  logic [ADDR_WIDTH-1:0]         post_count_in,
    input  logic                          parity_error_in,
    input  logic                          host_data_ready_in,
    input  logic                          network_data_ready_in,
    input  logic                          network_ack_in,
    input  logic [DATA_SIZE-1:0]          host_data_in,
    input  logic [DATA_SIZE+TAG_SIZE-1:0] ndt_in,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_waddr,
    output logic [LOG_WIDTH-1:0]          mem_wdata,
    output logic                          mem_re,
    output logic [ADDR_WIDTH-1:0]         mem_raddr,
    input  logic [LOG_WIDTH-1:0]          mem_rdata,
    input  logic                          rd_start_in,
    output logic                          rd_valid,
    output logic [LOG_WIDTH-1:0]          rd_data,
    output logic                          rd_last,
    input  logic                          rd_ready_in,
    output logic [2:0]                    state_out,
    output logic                          wrapped_out,
    output logic [ADDR_WIDTH-1:0]         trig_addr_out,
    output logic                          busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_POST    = 3'd2,
        S_DONE    = 3'd3,
        S_READOUT = 3'd4
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wrPtr;
    logic [ADDR_WIDTH-1:0] r_trigAddr;
    logic [ADDR_WIDTH-1:0] r_postCnt;
    logic [ADDR_WIDTH-1:0] r_rdAddr;
    logic [ADDR_WIDTH:0]   r_rdRemain;
    logic                  r_wrapped;
    logic                  r_rdFirst;
    logic                  r_rdPending;
    logic                  r_pendLast;
    logic                  r_rdValid;
    logic                  r_rdLast;
    logic [LOG_WIDTH-1:0]  r_rdData;

    logic w_we;
    logic w_trigger;
    logic w_handshake;
    logic w_memRe;

    assign w_we        = (r_state == S_ARMED) || (r_state == S_POST);
    assign w_trigger   = parity_error_in | stop_in;
    assign w_handshake = r_rdValid & rd_ready_in;
    // A read is issued on entry to readout and then in the same cycle as each handshake.
    assign w_memRe     = (r_state == S_READOUT) & (r_rdFirst | (w_handshake & ~r_rdLast));

    assign mem_we      = w_we;
    assign mem_waddr   = r_wrPtr;
    assign mem_wdata   = w_we ? {parity_error_in, host_data_ready_in, network_data_ready_in,
                                 network_ack_in, host_data_in, ndt_in} : '0;
    assign mem_re      = w_memRe;
    assign mem_raddr   = r_rdAddr;
    assign rd_valid    = r_rdValid;
    assign rd_data     = r_rdData;
    assign rd_last     = r_rdLast;
    assign state_out   = r_state;
    assign wrapped_out = r_wrapped;
    assign trig_addr_out = r_trigAddr;
    assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wrPtr     <= '0;
            r_trigAddr  <= '0;
            r_postCnt   <= '0;
            r_rdAddr    <= '0;
            r_rdRemain  <= '0;
            r_wrapped   <= 1'b0;
            r_rdFirst   <= 1'b0;
            r_rdPending <= 1'b0;
            r_pendLast  <= 1'b0;
            r_rdValid   <= 1'b0;
            r_rdLast    <= 1'b0;
            r_rdData    <= '0;
        end else begin
            if (w_we) begin
                r_wrPtr <= r_wrPtr + 1'b1;
                if (r_wrPtr == '1) begin
                    r_wrapped <= 1'b1;
                end
            end

            // RAM data arrives the cycle after the read; it is registered here.
            if (r_rdPending) begin
                r_rdData    <= mem_rdata;
                r_rdValid   <= 1'b1;
                r_rdLast    <= r_pendLast;
                r_rdPending <= 1'b0;
            end else if (w_handshake) begin
                r_rdValid <= 1'b0;
                r_rdLast  <= 1'b0;
            end

            if (w_memRe) begin
                r_rdAddr    <= r_rdAddr + 1'b1;
                r_rdRemain  <= r_rdRemain - 1'b1;
                r_pendLast  <= (r_rdRemain == (ADDR_WIDTH+1)'(1));
                r_rdPending <= 1'b1;
                r_rdFirst   <= 1'b0;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (arm_in) begin
                        r_state    <= S_ARMED;
                        r_wrPtr    <= '0;
                        r_wrapped  <= 1'b0;
                        r_trigAddr <= '0;
                    end else if ((r_state == S_DONE) && rd_start_in) begin
                        r_state    <= S_READOUT;
                        r_rdAddr   <= r_wrapped ? r_wrPtr : '0;
                        r_rdRemain <= r_wrapped ? (ADDR_WIDTH+1)'(DEPTH) : {1'b0, r_wrPtr};
                        r_rdFirst  <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (w_trigger) begin
                        r_trigAddr <= r_wrPtr;
                        r_postCnt  <= post_count_in;
                        r_state    <= (post_count_in == '0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    r_postCnt <= r_postCnt - 1'b1;
                    if (r_postCnt == ADDR_WIDTH'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_READOUT: begin
                    if (w_handshake && r_rdLast) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
